audio_tone_ctrl_mc: RTL and testbench

Multi-channel successor to the single-tone audio controller. An AXI-Lite-style write-only slave programs NUM_CH independent square-wave tone generators, each with its own half-period and volume. The channel outputs are summed and driven out as a 1-bit PWM audio signal. Sits between the bus interconnect and the board audio pin.

---
 rtl/audio_tone_ctrl_mc_pkg.sv | 29 ++
 rtl/audio_tone_ctrl_mc_tone_channel.sv | 66 ++++++
 rtl/audio_tone_ctrl_mc.sv | 158 +++++++++++++++
 tb/tb_audio_tone_ctrl_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_tone_ctrl_mc_pkg.sv
// Shared definitions for the multi-channel tone controller: register fields,
// response codes, bus states and width helpers.
package audio_tone_ctrl_mc_pkg;

  localparam logic       FIELD_HALF  = 1'b0;
  localparam logic       FIELD_CTRL  = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HAVE_ADDR,
    S_HAVE_DATA,
    S_RESP
  } bus_state_t;

  // Enable sits directly above the volume field in a control write.
  function automatic int unsigned en_bit_pos(input int unsigned vol_w);
    return vol_w;
  endfunction

  function automatic int unsigned pwm_width(input int unsigned vol_w, input int unsigned num_ch);
    int unsigned w;
    w = $clog2(num_ch);
    if (w < 1) w = 1;
    return vol_w + w;
  endfunction

endpackage

// File: rtl/audio_tone_ctrl_mc_tone_channel.sv
// One square-wave tone channel: half-period/enable/volume registers, tick
// counter and phase; emits the phase-gated volume and a registered active flag.
module tone_channel
  import audio_tone_ctrl_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned VOL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick,
  input  logic              i_wr_half,
  input  logic              i_wr_ctrl,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [VOL_W-1:0]  o_vol,
  output logic              o_active
);

  localparam int unsigned EN_BIT = en_bit_pos(VOL_W);

  logic [DATA_W-1:0] r_half;
  logic [DATA_W-1:0] r_cnt;
  logic [VOL_W-1:0]  r_vol;
  logic              r_en;
  logic              r_phase;
  logic              r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half   <= '0;
      r_cnt    <= '0;
      r_vol    <= '0;
      r_en     <= 1'b0;
      r_phase  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_active <= r_en & (r_half != '0);
      if (i_wr_half) begin
        r_half  <= i_wdata;
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else begin
        if (i_wr_ctrl) begin
          r_en  <= i_wdata[EN_BIT];
          r_vol <= i_wdata[VOL_W-1:0];
        end
        // A register write coinciding with a tick takes priority and clears the waveform.
        if (i_tick) begin
          if (i_wr_ctrl || (r_half == '0) || !r_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end else if (r_cnt == r_half - DATA_W'(1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_cnt <= r_cnt + DATA_W'(1);
          end
        end
      end
    end
  end

  assign o_vol    = r_phase ? r_vol : '0;
  assign o_active = r_active;

endmodule

// File: rtl/audio_tone_ctrl_mc.sv
// Multi-channel tone controller: write-only AXI-Lite-style slave, shared
// prescaler, per-channel tone generators, summing mixer and PWM output.
module audio_tone_ctrl_mc
  import audio_tone_ctrl_mc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic              aud_out,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int unsigned CH_W  = ADDR_W - 1;
  localparam int unsigned PWM_W = pwm_width(VOL_W, NUM_CH);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  bus_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_bresp;
  logic              w_aw_acc, w_w_acc, w_wr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [CH_W-1:0]   w_wr_ch;
  logic              w_wr_field;
  logic              w_ch_ok;

  assign AWREADY  = (r_state == S_IDLE) || (r_state == S_HAVE_DATA);
  assign WREADY   = (r_state == S_IDLE) || (r_state == S_HAVE_ADDR);
  assign BVALID   = (r_state == S_RESP);
  assign BRESP    = r_bresp;
  assign w_aw_acc = AWVALID & AWREADY;
  assign w_w_acc  = WVALID & WREADY;

  // The write lands on the edge that completes the pair, mixing held and live beats.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_addr   = r_addr;
    w_wr_data   = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_aw_acc && w_w_acc) begin
          w_wr        = 1'b1;
          w_wr_addr   = AWADDR;
          w_wr_data   = WDATA;
          w_state_nxt = S_RESP;
        end else if (w_aw_acc) begin
          w_state_nxt = S_HAVE_ADDR;
        end else if (w_w_acc) begin
          w_state_nxt = S_HAVE_DATA;
        end
      end
      S_HAVE_ADDR: begin
        if (w_w_acc) begin
          w_wr        = 1'b1;
          w_wr_data   = WDATA;
          w_state_nxt = S_RESP;
        end
      end
      S_HAVE_DATA: begin
        if (w_aw_acc) begin
          w_wr        = 1'b1;
          w_wr_addr   = AWADDR;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (BREADY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_ch    = w_wr_addr[ADDR_W-1:1];
  assign w_wr_field = w_wr_addr[0];
  assign w_ch_ok    = (32'(w_wr_ch) < NUM_CH);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_acc) r_addr <= AWADDR;
      if (w_w_acc)  r_data <= WDATA;
      if (w_wr)     r_bresp <= w_ch_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_pre <= '0;
    else          r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  logic [VOL_W-1:0] w_vol [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_channel #(
      .DATA_W (DATA_W),
      .VOL_W  (VOL_W)
    ) u_ch (
      .clk       (ACLK),
      .rst_n     (ARESETn),
      .i_tick    (w_tick),
      .i_wr_half (w_wr && w_ch_ok && (w_wr_ch == CH_W'(g)) && (w_wr_field == FIELD_HALF)),
      .i_wr_ctrl (w_wr && w_ch_ok && (w_wr_ch == CH_W'(g)) && (w_wr_field == FIELD_CTRL)),
      .i_wdata   (w_wr_data),
      .o_vol     (w_vol[g]),
      .o_active  (ch_active[g])
    );
  end

  logic [PWM_W-1:0] w_level;
  logic [PWM_W-1:0] r_pwm;
  logic             r_aud;

  always_comb begin
    w_level = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_level = w_level + PWM_W'(w_vol[i]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_pwm <= '0;
      r_aud <= 1'b0;
    end else begin
      r_pwm <= r_pwm + PWM_W'(1);
      r_aud <= (r_pwm < w_level);
    end
  end

  assign aud_out = r_aud;

endmodule

// File: tb/tb_audio_tone_ctrl_mc.sv
// Bench for audio_tone_ctrl_mc: directed and random bus writes checked every
// cycle against a behavioural model of the registers, tones, mixer and PWM.
module tb_audio_tone_ctrl_mc;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 16;
  localparam int VOL_W    = 4;
  localparam int PRESCALE = 10;
  localparam int ADDR_W   = 4;
  localparam int PWM_W    = VOL_W + (($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH));
  localparam int PWM_MOD  = 1 << PWM_W;

  logic              ACLK;
  logic              ARESETn;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic              aud_out;
  logic [NUM_CH-1:0] ch_active;

  audio_tone_ctrl_mc #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .VOL_W    (VOL_W),
    .PRESCALE (PRESCALE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .BRESP     (BRESP),
    .aud_out   (aud_out),
    .ch_active (ch_active)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int m_half [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_vol  [NUM_CH];
  bit m_en   [NUM_CH];
  bit m_ph   [NUM_CH];
  bit m_act  [NUM_CH];
  int m_pre, m_pwm, m_addr, m_data, m_resp;
  bit m_aud, m_aw_held, m_w_held, m_bv;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_half[c] = 0; m_cnt[c] = 0; m_vol[c] = 0;
      m_en[c] = 0; m_ph[c] = 0; m_act[c] = 0;
    end
    m_pre = 0; m_pwm = 0; m_addr = 0; m_data = 0; m_resp = 0;
    m_aud = 0; m_aw_held = 0; m_w_held = 0; m_bv = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int lvl, ch, fld;
    bit tick, aw_acc, w_acc, do_wr;
    if (!ARESETn) begin
      model_reset();
      return;
    end
    lvl = 0;
    for (int c = 0; c < NUM_CH; c++) lvl += m_ph[c] ? m_vol[c] : 0;
    m_aud = (m_pwm < lvl);
    m_pwm = (m_pwm + 1) % PWM_MOD;
    tick  = (m_pre == PRESCALE - 1);
    m_pre = tick ? 0 : m_pre + 1;

    aw_acc = AWVALID && !m_aw_held && !m_bv;
    w_acc  = WVALID && !m_w_held && !m_bv;
    do_wr  = 0;
    if (m_bv) begin
      if (BREADY) m_bv = 0;
    end else begin
      if (aw_acc) begin m_addr = int'(AWADDR); m_aw_held = 1; end
      if (w_acc)  begin m_data = int'(WDATA);  m_w_held = 1; end
      if (m_aw_held && m_w_held) begin
        do_wr = 1; m_aw_held = 0; m_w_held = 0; m_bv = 1;
        m_resp = ((m_addr >> 1) >= NUM_CH) ? 2 : 0;
      end
    end
    ch  = m_addr >> 1;
    fld = m_addr & 1;

    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = m_en[c] && (m_half[c] != 0);
      if (do_wr && ch == c && fld == 0) begin
        m_half[c] = m_data; m_cnt[c] = 0; m_ph[c] = 0;
      end else begin
        if (do_wr && ch == c && fld == 1) begin
          m_en[c]  = (m_data >> VOL_W) & 1;
          m_vol[c] = m_data % (1 << VOL_W);
          if (tick) begin m_cnt[c] = 0; m_ph[c] = 0; end
        end else if (tick) begin
          if (m_half[c] == 0 || !m_en[c]) begin
            m_cnt[c] = 0; m_ph[c] = 0;
          end else if (m_cnt[c] == m_half[c] - 1) begin
            m_cnt[c] = 0; m_ph[c] = !m_ph[c];
          end else begin
            m_cnt[c]++;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] act;
    for (int c = 0; c < NUM_CH; c++) act[c] = m_act[c];
    check("awready",   32'(AWREADY),   32'(!m_aw_held && !m_bv));
    check("wready",    32'(WREADY),    32'(!m_w_held && !m_bv));
    check("bvalid",    32'(BVALID),    32'(m_bv));
    check("bresp",     32'(BRESP),     32'(m_resp));
    check("aud_out",   32'(aud_out),   32'(m_aud));
    check("ch_active", 32'(ch_active), 32'(act));
  endtask

  task automatic step();
    model_edge();
    @(posedge ACLK);
    #1;
    compare_all();
  endtask

  // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W.
  task automatic wr(input int addr, input int data, input int lead, input int b_delay);
    BREADY = 1'b0;
    if (lead > 0) begin
      WVALID = 1'b1; WDATA = DATA_W'(data);
      step();
      WVALID = 1'b0;
      repeat (lead - 1) step();
      AWVALID = 1'b1; AWADDR = ADDR_W'(addr);
      step();
      AWVALID = 1'b0;
    end else if (lead < 0) begin
      AWVALID = 1'b1; AWADDR = ADDR_W'(addr);
      step();
      AWVALID = 1'b0;
      repeat (-lead - 1) step();
      WVALID = 1'b1; WDATA = DATA_W'(data);
      step();
      WVALID = 1'b0;
    end else begin
      AWVALID = 1'b1; AWADDR = ADDR_W'(addr);
      WVALID  = 1'b1; WDATA  = DATA_W'(data);
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    repeat (b_delay) step();
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  initial begin
    int addr, data;
    ARESETn = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (3) step();
    ARESETn = 1'b1;
    repeat (1000) step();

    // ch0 half-period 5, ch0 enabled at full volume
    wr(0, 'h0005, 0, 0);
    wr(1, 'h001F, 0, 0);
    repeat (300) step();

    // W leads AW by 3 cycles, response held off for 5 cycles
    wr(2, 4, 3, 5);
    repeat (20) step();

    // Out-of-range channel 5
    wr('hA, 'h001F, 0, 0);
    repeat (20) step();

    // All channels at full volume, then silence ch2 via a zero half-period
    for (int c = 0; c < NUM_CH; c++) begin
      wr(2 * c, 3, 0, 0);
      wr(2 * c + 1, 'h1F, 0, 0);
    end
    repeat (200) step();
    wr(4, 0, 0, 1);
    repeat (150) step();

    for (int n = 0; n < 40; n++) begin
      addr = int'($urandom_range(0, 15));
      data = (addr % 2 == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      wr(addr, data, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 80)) step();
    end

    // Asynchronous reset while a response is outstanding
    AWVALID = 1'b1; AWADDR = 4'h3; WVALID = 1'b1; WDATA = 16'h0019;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    #2;
    ARESETn = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    ARESETn = 1'b1;
    repeat (200) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
